// File: rtl/multi_channel_consumer.sv
// rtl/multi_channel_consumer.sv - N-channel result sink with per-channel FIFOs and round-robin merge
//
// Purpose: each pipeline channel pushes results into its own small FIFO over a
// valid/ready handshake. A registered round-robin stage merges the FIFOs onto one
// tagged output stream. Any full FIFO raises global_stall. The last accepted word
// of every channel is kept for debug.
// Optional feature: define CONSUMER_STATS_EN to build saturating 16-bit
// per-channel accept counters. Otherwise accept_count is tied to zero.
// Ports:
//   clk           clock, all state on the rising edge
//   reset_n       asynchronous active-low reset
//   in_data       per-channel input words, channel c at [c*DATA_W +: DATA_W]
//   in_valid      per-channel input valid
//   in_ready      per-channel FIFO not full
//   global_stall  high while any channel FIFO is full
//   out_data      merged output word
//   out_ch        source channel of out_data
//   out_valid     output slot holds a word
//   out_ready     downstream accepts the output word
//   last_data     last accepted word per channel
//   accept_count  per-channel accepted-push counters, 16 bits each
module multi_channel_consumer #(
   parameter int  NUM_CH = 2,
   parameter int  DATA_W = 32,
   parameter int  DEPTH  = 4,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     global_stall,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH*DATA_W-1:0] last_data,
   output logic [NUM_CH*16-1:0]     accept_count
);

   localparam int             PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
   logic [PTR_W-1:0]  wr_ptr [NUM_CH];
   logic [PTR_W-1:0]  rd_ptr [NUM_CH];
   logic [PTR_W:0]    count  [NUM_CH];

   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   grant_ch;
   logic              grant_vld;
   logic              load;

   // Full is decided on the registered count only, so a full FIFO never takes a
   // push even when it is being popped in the same cycle.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         full[c]  = (count[c] == FULL_CNT);
         empty[c] = (count[c] == '0);
         push[c]  = in_valid[c] & ~full[c];
      end
   end

   assign in_ready     = ~full;
   assign global_stall = |full;
   assign load         = ~out_valid | out_ready;

   // Round-robin search starting one past the last granted channel. Only entries
   // already stored in the FIFOs are visible, so there is no same-cycle fall-through.
   always_comb begin
      int              n;
      logic [CH_W-1:0] cand;
      grant_vld = 1'b0;
      grant_ch  = '0;
      n         = 0;
      cand      = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         n = int'(rr_ptr) + i;
         if (n >= NUM_CH) n = n - NUM_CH;
         cand = CH_W'(n);
         if (!grant_vld && !empty[cand]) begin
            grant_vld = 1'b1;
            grant_ch  = cand;
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         pop[c] = load & grant_vld & (grant_ch == CH_W'(c));
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (push[c]) mem[c][wr_ptr[c]] <= in_data[c*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            count[c]  <= '0;
         end
         last_data <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
               wr_ptr[c]                    <= wr_ptr[c] + PTR_W'(1);
               last_data[c*DATA_W +: DATA_W] <= in_data[c*DATA_W +: DATA_W];
            end
            if (pop[c]) rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
            count[c] <= count[c] + (PTR_W+1)'(push[c]) - (PTR_W+1)'(pop[c]);
         end
      end
   end

   // Output slot: refills whenever it is empty or being drained; data and tag
   // hold their last values when the slot goes idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         rr_ptr    <= CH_W'(NUM_CH - 1);
      end else if (load) begin
         if (grant_vld) begin
            out_data  <= mem[grant_ch][rd_ptr[grant_ch]];
            out_ch    <= grant_ch;
            out_valid <= 1'b1;
            rr_ptr    <= grant_ch;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef CONSUMER_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         accept_count <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (push[c] && (accept_count[c*16 +: 16] != 16'hFFFF))
               accept_count[c*16 +: 16] <= accept_count[c*16 +: 16] + 16'd1;
         end
      end
   end
`else
   assign accept_count = '0;
`endif

endmodule

// File: tb/tb_multi_channel_consumer.sv
// tb/tb_multi_channel_consumer.sv - directed self-checking bench for multi_channel_consumer
module tb_multi_channel_consumer;

   logic        clk;
   logic        reset_n;
   logic [63:0] in_data;
   logic [1:0]  in_valid;
   logic [1:0]  in_ready;
   logic        global_stall;
   logic [31:0] out_data;
   logic        out_ch;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] last_data;
   logic [31:0] accept_count;

   int vectors = 0;
   int errors  = 0;

   multi_channel_consumer #(.NUM_CH(2), .DATA_W(32), .DEPTH(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .global_stall (global_stall),
      .out_data     (out_data),
      .out_ch       (out_ch),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .last_data    (last_data),
      .accept_count (accept_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [31:0] exp_d [7];
   logic        exp_c [7];

   initial begin
      reset_n   = 1'b0;
      in_data   = '0;
      in_valid  = 2'b00;
      out_ready = 1'b1;
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_in_ready", in_ready, 2'b11);
      check("rst_stall", global_stall, 0);
      check("rst_last_data", last_data, 0);
      check("rst_accept_count", accept_count, 0);
      reset_n = 1'b1;
      tick();

      // single word on ch0: no fall-through, visible one edge later
      in_data  = {32'h0, 32'hA5A5_0001};
      in_valid = 2'b01;
      tick();
      check("t2_no_fallthrough", out_valid, 0);
      in_valid = 2'b00;
      tick();
      check("t2_out_valid", out_valid, 1);
      check("t2_out_data", out_data, 32'hA5A5_0001);
      check("t2_out_ch", out_ch, 0);
      check("t2_last_data0", last_data[31:0], 32'hA5A5_0001);
      tick();
      check("t2_drain_valid", out_valid, 0);
      check("t2_drain_hold", out_data, 32'hA5A5_0001);

      // traffic, then asynchronous reset between clock edges
      out_ready = 1'b0;
      in_data   = {32'hB000_0001, 32'hA000_0002};
      in_valid  = 2'b11;
      tick();
      in_valid = 2'b00;
      tick();
      check("mr_rr_ch1_first", out_ch, 1);
      check("mr_out_data", out_data, 32'hB000_0001);
      #3;
      reset_n = 1'b0;
      #1;
      check("mr_out_valid", out_valid, 0);
      check("mr_out_data_clr", out_data, 0);
      check("mr_out_ch_clr", out_ch, 0);
      check("mr_last_data_clr", last_data, 0);
      check("mr_in_ready", in_ready, 2'b11);
      tick();
      tick();
      reset_n = 1'b1;

      // round robin: slot a0, ch0 FIFO a1..a3, ch1 FIFO b0..b2
      out_ready = 1'b0;
      in_valid  = 2'b11;
      in_data   = {32'hB300_0000, 32'hA300_0000};
      tick();
      in_data   = {32'hB300_0001, 32'hA300_0001};
      tick();
      in_data   = {32'hB300_0002, 32'hA300_0002};
      tick();
      in_valid  = 2'b01;
      in_data   = {32'h0, 32'hA300_0003};
      tick();
      check("t3_stall_low", global_stall, 0);
      in_valid  = 2'b00;
      out_ready = 1'b1;
      exp_d[0] = 32'hA300_0000; exp_c[0] = 1'b0;
      exp_d[1] = 32'hB300_0000; exp_c[1] = 1'b1;
      exp_d[2] = 32'hA300_0001; exp_c[2] = 1'b0;
      exp_d[3] = 32'hB300_0001; exp_c[3] = 1'b1;
      exp_d[4] = 32'hA300_0002; exp_c[4] = 1'b0;
      exp_d[5] = 32'hB300_0002; exp_c[5] = 1'b1;
      exp_d[6] = 32'hA300_0003; exp_c[6] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check($sformatf("t3_ch_%0d", i), out_ch, exp_c[i]);
         check($sformatf("t3_data_%0d", i), out_data, exp_d[i]);
         tick();
      end
      check("t3_empty", out_valid, 0);

      // backpressure on ch1
      out_ready = 1'b0;
      in_valid  = 2'b10;
      for (int k = 0; k < 5; k++) begin
         in_data = {32'hC400_0000 + 32'(k), 32'h0};
         tick();
      end
      check("t4_in_ready", in_ready, 2'b01);
      check("t4_stall", global_stall, 1);
      check("t4_slot_data", out_data, 32'hC400_0000);
      check("t4_slot_ch", out_ch, 1);
      in_data = {32'hC400_0005, 32'h0};
      tick();
      check("t4_refused_stall", global_stall, 1);
      check("t4_held_data", out_data, 32'hC400_0000);
      check("t4_held_valid", out_valid, 1);
      check("t4_refused_last", last_data[63:32], 32'hC400_0004);
      in_valid  = 2'b00;
      out_ready = 1'b1;
      tick();
      check("t4_stall_drop", global_stall, 0);
      check("t4_ready_back", in_ready, 2'b11);
      check("t4_pop1", out_data, 32'hC400_0001);
      tick();
      check("t4_pop2", out_data, 32'hC400_0002);
      tick();
      check("t4_pop3", out_data, 32'hC400_0003);
      tick();
      check("t4_pop4", out_data, 32'hC400_0004);
      tick();
      check("t4_empty", out_valid, 0);

      // simultaneous push and pop on ch0 at count 2
      out_ready = 1'b0;
      in_valid  = 2'b01;
      in_data   = {32'h0, 32'hD500_0000};
      tick();
      in_data   = {32'h0, 32'hD500_0001};
      tick();
      in_data   = {32'h0, 32'hD500_0002};
      tick();
      check("t5_slot", out_data, 32'hD500_0000);
      out_ready = 1'b1;
      in_data   = {32'h0, 32'hD500_0003};
      tick();
      check("t5_pushpop", out_data, 32'hD500_0001);
      in_valid = 2'b00;
      tick();
      check("t5_next2", out_data, 32'hD500_0002);
      tick();
      check("t5_next3", out_data, 32'hD500_0003);
      check("t5_valid3", out_valid, 1);
      tick();
      check("t5_empty", out_valid, 0);

      // accept counters: 8 accepted on each channel since the mid-traffic reset
`ifdef CONSUMER_STATS_EN
      check("t6_accum", accept_count, {16'd8, 16'd8});
`else
      check("t6_accum", accept_count, 0);
`endif
      reset_n = 1'b0;
      #1;
      check("t6_clear", accept_count, 0);
      tick();
      reset_n  = 1'b1;
      in_valid = 2'b10;
      for (int k = 0; k < 3; k++) begin
         in_data = {32'hE600_0000 + 32'(k), 32'h0};
         tick();
      end
      in_valid = 2'b00;
      tick();
`ifdef CONSUMER_STATS_EN
      check("t6_ch1_count", accept_count, {16'd3, 16'd0});
`else
      check("t6_ch1_count", accept_count, 0);
`endif

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
